lcd_char_driver: RTL
====================

# lcd_char_driver

Character-LCD back end for the lock-in front panel. Holds a 32-byte character buffer that the binary-to-LCD formatter fills through a byte write port (dat/addr/we). Initialises an HD44780-compatible 16x2 display in 4-bit mode and refreshes both lines from the buffer forever, pulsing `update` once per frame so the formatter re-renders the next measurement.

## Interface
- `POWERUP_CYC`, 750000: idle cycles after reset before the first init nibble.
- `INIT_WAIT_CYC`, 250000: wait after each of the four raw init nibbles.
- `E_SETUP_CYC`, 2: cycles RS/D stable with E low before E rises.
- `E_PULSE_CYC`, 12: cycles E held high.
- `E_HOLD_CYC`, 2: cycles E low with RS/D held after E falls.
- `CMD_WAIT_CYC`, 2500: idle after every full byte.
- `CLEAR_WAIT_CYC`, 100000: extra idle after the clear command.
- `REFRESH_GAP_CYC`, 1000000: idle between frames.
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `dat` in 8: character code to store.
- `addr` in 5: buffer index; 0-15 line 1, 16-31 line 2.
- `we` in 1: write strobe, one byte per cycle when high.
- `update` out 1: one-cycle pulse at end of each frame.
- `ready` out 1: high once init is complete; stays high until reset.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: constant 0 (write-only).
- `lcd_e` out 1: enable strobe.
- `lcd_d` out 4: data nibble, LCD D7..D4.

## Operation
- Buffer: 32x8 registers. `we` high at a rising edge: `buf[addr] <= dat`, accepted in every state, including during reset release. The reader fetches a byte at the start of its high-nibble setup; a same-cycle write to that index is not seen until the next frame.
- Reset: buffer filled with 0x20; FSM to PWRUP; counters cleared.
- FSM states: PWRUP -> INIT_NIB (raw nibbles 0x3, 0x3, 0x3, 0x2, RS=0, each followed by INIT_WAIT_CYC) -> INIT_CMD (bytes 0x28, 0x0C, 0x06, 0x01, RS=0; 0x01 is followed by CMD_WAIT_CYC + CLEAR_WAIT_CYC) -> `ready` set -> LINE1_ADDR (cmd 0x80) -> LINE1_CHARS (RS=1, buf[0..15]) -> LINE2_ADDR (cmd 0xC0) -> LINE2_CHARS (RS=1, buf[16..31]) -> FRAME_END (`update`=1 for one cycle) -> GAP (REFRESH_GAP_CYC) -> LINE1_ADDR.
- Byte transfer: high nibble `d[7:4]`, then low nibble `d[3:0]`, then CMD_WAIT_CYC idle with `lcd_e`=0.
- Nibble transfer: `lcd_rs`/`lcd_d` are updated in the first setup cycle and held through setup, pulse and hold. `lcd_e`=1 only during the E_PULSE_CYC cycles.
- Between transfers, `lcd_d` and `lcd_rs` keep their last values.
- Counters must be wide enough for the largest parameter; all wait parameters are at least 1.

## Timing
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_d`=0, `update`=0, `ready`=0.
- Nibble = S+P+H cycles, where S=E_SETUP_CYC, P=E_PULSE_CYC, H=E_HOLD_CYC. Byte = 2(S+P+H)+CMD_WAIT_CYC.
- First `lcd_e` rise occurs POWERUP_CYC+S cycles after the first cycle with `rst_n`=1.
- `ready` rises in the cycle after the clear wait ends. The 0x80 setup phase begins in that same cycle.
- Frame = 34 bytes. `update` pulses in the cycle after the CMD_WAIT of buf[31]. The 0x80 setup begins REFRESH_GAP_CYC cycles after the `update` cycle.
- `rst_n`=0 mid-transfer: the next edge forces `lcd_e`=0 and all reset values; the sequence restarts from PWRUP (full re-init).
- `rst_n`=0 takes priority over `we` in the same cycle: the buffer is refilled with 0x20.

## Test plan
Parameters for all scenarios: POWERUP=10, INIT_WAIT=5, S=1, P=2, H=1, CMD_WAIT=3, CLEAR_WAIT=4, GAP=6.
- Reset/init: release `rst_n` -> outputs at reset values for 10 cycles; nibble sequence on `lcd_d` is 3,3,3,2,2,8,0,C,0,6,0,1 with `lcd_rs`=0; `ready` rises afterwards.
- E timing: capture one byte -> `lcd_e` high exactly 2 cycles per nibble; `lcd_d` stable 1 cycle before the rise and 1 cycle after the fall; 11 cycles per byte.
- Frame content: write "X: 1.2345" at 0..8 and "Y:-0.0001" at 16..24 -> decoded stream is 0x80, 16 line-1 chars with unwritten slots = 0x20, 0xC0, 16 line-2 chars, all chars with RS=1.
- Update handshake: measure `update` -> exactly one 1-cycle pulse per frame; next 0x80 setup begins 6 cycles later; period constant across 3 frames.
- Write collision: write addr 5 = 0x41 in the cycle buf[5] is fetched -> the old value is displayed this frame, 0x41 the next frame.
- Mid-operation reset: assert `rst_n` low while `lcd_e`=1 in LINE2_CHARS -> `lcd_e`=0 the next cycle, `ready`=0, the buffer reads back 0x20, and the full init repeats.

Source files
------------

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: character-LCD back end for a 16x2 HD44780-compatible display.
// It keeps a 32-byte character buffer that the formatter fills through a byte
// write port. It initialises the display in 4-bit mode, then refreshes both
// lines forever and pulses update_o once at the end of every frame.
//
// Ports
//   clk_i      system clock
//   rst_n_i    synchronous active-low reset (buffer refilled with spaces)
//   dat_i      character code to store
//   addr_i     buffer index: 0-15 line 1, 16-31 line 2
//   we_i       write strobe, one byte per cycle
//   update_o   one-cycle pulse at the end of each frame
//   ready_o    high once the init sequence has completed
//   lcd_rs_o   0 = command, 1 = data
//   lcd_rw_o   tied low (write-only)
//   lcd_e_o    enable strobe
//   lcd_d_o    data nibble D7..D4
//
// state        | meaning
// -------------+--------------------------------------------------------
// PWRUP        | power-up delay before the first raw nibble
// INIT_NIB     | raw nibbles 3,3,3,2 (RS=0), each followed by the init wait
// INIT_CMD     | bytes 28,0C,06,01 (RS=0); the clear gets an extra wait
// LINE1_ADDR   | DDRAM address command 0x80
// LINE1_CHARS  | buffer bytes 0..15 (RS=1)
// LINE2_ADDR   | DDRAM address command 0xC0
// LINE2_CHARS  | buffer bytes 16..31 (RS=1)
// FRAME_END    | update pulse cycle; it is also the first refresh-gap cycle
// GAP          | remainder of the refresh gap
module lcd_char_driver #(
    parameter int unsigned POWERUP_CYC     = 750000,
    parameter int unsigned INIT_WAIT_CYC   = 250000,
    parameter int unsigned E_SETUP_CYC     = 2,
    parameter int unsigned E_PULSE_CYC     = 12,
    parameter int unsigned E_HOLD_CYC      = 2,
    parameter int unsigned CMD_WAIT_CYC    = 2500,
    parameter int unsigned CLEAR_WAIT_CYC  = 100000,
    parameter int unsigned REFRESH_GAP_CYC = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] dat_i,
    input  logic [4:0] addr_i,
    input  logic       we_i,
    output logic       update_o,
    output logic       ready_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [3:0] lcd_d_o
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned CLR_TOTAL = CMD_WAIT_CYC + CLEAR_WAIT_CYC;
    localparam int unsigned MAX_CYC   = max_u(max_u(max_u(POWERUP_CYC, INIT_WAIT_CYC),
                                                    max_u(E_SETUP_CYC, E_PULSE_CYC)),
                                              max_u(max_u(E_HOLD_CYC, CLR_TOTAL),
                                                    REFRESH_GAP_CYC));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters load N-1 and move on when they reach zero, giving N cycles.
    localparam cnt_t LD_PWRUP     = cnt_t'(POWERUP_CYC - 1);
    localparam cnt_t LD_INIT_WAIT = cnt_t'(INIT_WAIT_CYC - 1);
    localparam cnt_t LD_SETUP     = cnt_t'(E_SETUP_CYC - 1);
    localparam cnt_t LD_PULSE     = cnt_t'(E_PULSE_CYC - 1);
    localparam cnt_t LD_HOLD      = cnt_t'(E_HOLD_CYC - 1);
    localparam cnt_t LD_CMD       = cnt_t'(CMD_WAIT_CYC - 1);
    localparam cnt_t LD_CLEAR     = cnt_t'(CLR_TOTAL - 1);
    localparam cnt_t LD_GAP       = cnt_t'(REFRESH_GAP_CYC - 1);

    typedef enum logic [3:0] {
        ST_PWRUP, ST_INIT_NIB, ST_INIT_CMD, ST_LINE1_ADDR, ST_LINE1_CHARS,
        ST_LINE2_ADDR, ST_LINE2_CHARS, ST_FRAME_END, ST_GAP
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    logic [7:0] char_q [32];

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    cnt_t       cnt_q, cnt_d, cnt_dec;
    logic [3:0] idx_q, idx_d, idx_nxt;
    logic [3:0] lo_q, lo_d;
    logic       hi_q, hi_d;
    logic       raw_q, raw_d;
    logic       rs_q, rs_d;
    logic [3:0] d_q, d_d;
    logic       e_q, e_d;
    logic       ready_q, ready_d;
    logic       update_q, update_d;

    logic       launch;
    logic       launch_raw;
    logic       launch_rs;
    logic [7:0] launch_val;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) char_q[i] <= 8'h20;
        end else if (we_i) begin
            char_q[addr_i] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_PWRUP;
            phase_q  <= PH_SETUP;
            cnt_q    <= LD_PWRUP;
            idx_q    <= '0;
            lo_q     <= '0;
            hi_q     <= 1'b0;
            raw_q    <= 1'b0;
            rs_q     <= 1'b0;
            d_q      <= '0;
            e_q      <= 1'b0;
            ready_q  <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            raw_q    <= raw_d;
            rs_q     <= rs_d;
            d_q      <= d_d;
            e_q      <= e_d;
            ready_q  <= ready_d;
            update_q <= update_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        raw_d      = raw_q;
        rs_d       = rs_q;
        d_d        = d_q;
        e_d        = e_q;
        ready_d    = ready_q;
        update_d   = 1'b0;
        launch     = 1'b0;
        launch_raw = 1'b0;
        launch_rs  = 1'b0;
        launch_val = '0;
        idx_nxt    = idx_q + 4'd1;
        cnt_dec    = cnt_q - cnt_t'(1);

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == '0) begin
                    launch     = 1'b1;
                    launch_raw = 1'b1;
                    launch_val = 8'h30;
                    state_d    = ST_INIT_NIB;
                    idx_d      = '0;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_FRAME_END, ST_GAP: begin
                if (cnt_q == '0) begin
                    launch     = 1'b1;
                    launch_val = 8'h80;
                    state_d    = ST_LINE1_ADDR;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_dec;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == '0) begin
                            phase_d = PH_PULSE;
                            e_d     = 1'b1;
                            cnt_d   = LD_PULSE;
                        end else cnt_d = cnt_dec;
                    end
                    PH_PULSE: begin
                        if (cnt_q == '0) begin
                            phase_d = PH_HOLD;
                            e_d     = 1'b0;
                            cnt_d   = LD_HOLD;
                        end else cnt_d = cnt_dec;
                    end
                    PH_HOLD: begin
                        if (cnt_q == '0) begin
                            if (hi_q && !raw_q) begin
                                phase_d = PH_SETUP;
                                hi_d    = 1'b0;
                                d_d     = lo_q;
                                cnt_d   = LD_SETUP;
                            end else begin
                                phase_d = PH_WAIT;
                                if (raw_q)
                                    cnt_d = LD_INIT_WAIT;
                                else if (state_q == ST_INIT_CMD && idx_q[1:0] == 2'd3)
                                    cnt_d = LD_CLEAR;
                                else
                                    cnt_d = LD_CMD;
                            end
                        end else cnt_d = cnt_dec;
                    end
                    default: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_dec;
                        end else begin
                            case (state_q)
                                ST_INIT_NIB: begin
                                    launch = 1'b1;
                                    if (idx_q[1:0] != 2'd3) begin
                                        idx_d      = idx_nxt;
                                        launch_raw = 1'b1;
                                        launch_val = (idx_nxt[1:0] == 2'd3) ? 8'h20 : 8'h30;
                                    end else begin
                                        state_d    = ST_INIT_CMD;
                                        idx_d      = '0;
                                        launch_val = init_cmd(2'd0);
                                    end
                                end
                                ST_INIT_CMD: begin
                                    launch = 1'b1;
                                    if (idx_q[1:0] != 2'd3) begin
                                        idx_d      = idx_nxt;
                                        launch_val = init_cmd(idx_nxt[1:0]);
                                    end else begin
                                        ready_d    = 1'b1;
                                        state_d    = ST_LINE1_ADDR;
                                        launch_val = 8'h80;
                                    end
                                end
                                ST_LINE1_ADDR: begin
                                    launch     = 1'b1;
                                    launch_rs  = 1'b1;
                                    launch_val = char_q[5'd0];
                                    state_d    = ST_LINE1_CHARS;
                                    idx_d      = '0;
                                end
                                ST_LINE1_CHARS: begin
                                    launch = 1'b1;
                                    if (idx_q != 4'd15) begin
                                        idx_d      = idx_nxt;
                                        launch_rs  = 1'b1;
                                        launch_val = char_q[{1'b0, idx_nxt}];
                                    end else begin
                                        state_d    = ST_LINE2_ADDR;
                                        launch_val = 8'hC0;
                                    end
                                end
                                ST_LINE2_ADDR: begin
                                    launch     = 1'b1;
                                    launch_rs  = 1'b1;
                                    launch_val = char_q[5'd16];
                                    state_d    = ST_LINE2_CHARS;
                                    idx_d      = '0;
                                end
                                ST_LINE2_CHARS: begin
                                    if (idx_q != 4'd15) begin
                                        launch     = 1'b1;
                                        idx_d      = idx_nxt;
                                        launch_rs  = 1'b1;
                                        launch_val = char_q[{1'b1, idx_nxt}];
                                    end else begin
                                        state_d  = ST_FRAME_END;
                                        update_d = 1'b1;
                                        cnt_d    = LD_GAP;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        endcase

        // The byte is captured here, on the edge that opens its high-nibble
        // setup, so a write landing on the same edge only shows next frame.
        if (launch) begin
            phase_d = PH_SETUP;
            cnt_d   = LD_SETUP;
            d_d     = launch_val[7:4];
            lo_d    = launch_val[3:0];
            hi_d    = 1'b1;
            raw_d   = launch_raw;
            rs_d    = launch_rs;
        end
    end

    assign update_o = update_q;
    assign ready_o  = ready_q;
    assign lcd_rs_o = rs_q;
    assign lcd_rw_o = 1'b0;
    assign lcd_e_o  = e_q;
    assign lcd_d_o  = d_q;

endmodule
